data_mem_access_sequencer: RTL and testbench
============================================

// Module: data_mem_access_sequencer
// PURPOSE
//   CPU-side initiator for the data memory manager. Accepts one load/store request per handshake
//   and turns it into the manager's strobe sequence: latch address, then read or write, then return.
//   For loads it captures the returned byte and presents it with a one-cycle response pulse.
//   Sits between the CPU execute stage and the data memory / IO port manager.
// PARAMETERS
//   ADDR_W        10  width of the data address (memory and IO port space)
//   DATA_W        8   width of the data bus
//   READ_LATENCY  1   cycles read_en is held before in_mem_data is sampled; legal range 1..15
// PORTS
//   clk                    in   1       system clock, all state changes on posedge
//   rst                    in   1       synchronous, active-high reset
//   in_req_valid           in   1       request present
//   out_req_ready          out  1       sequencer can accept a request (high only in IDLE)
//   in_req_write           in   1       1 = store, 0 = load
//   in_req_addr            in   ADDR_W  request address
//   in_req_data            in   DATA_W  store data (ignored for loads)
//   out_mem_addr_write_en  out  1       address-latch strobe to memory manager
//   out_mem_addr           out  ADDR_W  address to memory manager
//   out_mem_read_en        out  1       read strobe to memory manager
//   out_mem_write_en       out  1       write strobe to memory manager
//   out_mem_data           out  DATA_W  write data to memory manager
//   in_mem_data            in   DATA_W  read data from memory manager
//   out_resp_valid         out  1       one-cycle pulse: transaction complete
//   out_resp_data          out  DATA_W  captured load data; 0 after a store
// BEHAVIOUR
//   Reset: state=IDLE; all strobes 0; out_resp_valid 0; out_mem_addr, out_mem_data, out_resp_data 0;
//     out_req_ready 1 from the first cycle after reset deassert. Reset mid-transaction aborts:
//     strobes drop at that edge, no response pulse is issued, the aborted request is lost.
//   Handshake: accept on posedge where in_req_valid && out_req_ready. Request fields registered at
//     accept; inputs ignored at all other times. No backpressure on the response side.
//   FSM (all outputs registered or decoded from state only, never from request inputs):
//     IDLE   : ready=1. On accept -> ADDR.
//     ADDR   : out_mem_addr_write_en=1 for exactly one cycle. -> WRITE if store, else READ.
//     WRITE  : out_mem_write_en=1 for exactly one cycle. -> RESP.
//     READ   : out_mem_read_en=1 for READ_LATENCY cycles (4-bit down-counter loaded on ADDR exit);
//              in_mem_data sampled into out_resp_data on the edge ending the last READ cycle. -> RESP.
//     RESP   : out_resp_valid=1 for one cycle. -> IDLE.
//   Latency from accept edge to response cycle: store 3 cycles; load 2+READ_LATENCY cycles.
//   out_mem_addr and out_mem_data hold the registered request values from ADDR through RESP
//     (stable before and after every strobe); retain last values in IDLE.
//   Invariants: at most one of addr_write_en/read_en/write_en high in any cycle; ready=0 from
//     ADDR through RESP, so a valid held during a transaction is accepted only after RESP.
//   Store response: out_resp_data cleared to 0 at the WRITE->RESP edge.
//   Minimum request spacing: one accept every (response latency + 1) cycles; back-to-back
//     requests accepted in the IDLE cycle directly following RESP.
//   READ_LATENCY outside 1..15 is a configuration error (simulation $error at elaboration).
// TESTING
//   Reset: hold rst 3 cycles with valid=1 -> all strobes 0, resp_valid 0, ready 1 after release.
//   Store 0x3A to 0x155 -> addr_write_en 1 cycle later with addr=0x155, write_en next cycle with
//     data=0x3A, resp_valid the cycle after, resp_data=0x00.
//   Load 0x2C0, model returns 0xA5 -> addr_we, read_en 1 cycle, resp_valid with resp_data=0xA5
//     3 cycles after accept; write_en never asserted.
//   Back-to-back: valid held high for load then store -> second accept exactly one cycle after
//     first resp_valid; ready low throughout first transaction; strobes never overlap.
//   READ_LATENCY=3 build: load 0x3FF returning 0x5C -> read_en high 3 consecutive cycles,
//     resp_data=0x5C on resp_valid 5 cycles after accept.
//   Reset asserted during READ -> read_en 0 next cycle, no resp_valid, next request completes normally.

Source files
------------

// File: rtl/data_mem_access_sequencer.sv
// Purpose     : CPU-side initiator for the data memory manager; turns one load/store request
//               into the strobe sequence address-latch -> read|write -> response pulse.
// Latency     : accept edge to response cycle: store 3 cycles, load 2+READ_LATENCY cycles.
// Backpressure: out_req_ready is high only in IDLE; the response side has no backpressure.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   in_req_valid/out_req_ready request handshake (accept on valid && ready at posedge)
//   in_req_write/addr/data    request fields, registered at accept only
//   out_mem_addr_write_en     address-latch strobe to the memory manager
//   out_mem_addr/out_mem_data registered request address / store data
//   out_mem_read_en           read strobe, held READ_LATENCY cycles
//   out_mem_write_en          write strobe, one cycle
//   in_mem_data               read data, sampled at the end of the last read cycle
//   out_resp_valid            one-cycle completion pulse
//   out_resp_data             captured load data, 0 after a store
module data_mem_access_sequencer #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_req_valid,
  output logic              out_req_ready,
  input  logic              in_req_write,
  input  logic [ADDR_W-1:0] in_req_addr,
  input  logic [DATA_W-1:0] in_req_data,
  output logic              out_mem_addr_write_en,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_read_en,
  output logic              out_mem_write_en,
  output logic [DATA_W-1:0] out_mem_data,
  input  logic [DATA_W-1:0] in_mem_data,
  output logic              out_resp_valid,
  output logic [DATA_W-1:0] out_resp_data
);

  // The read-wait counter is 4 bits wide, so only 1..15 cycles are representable.
  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_read_latency
    $error("data_mem_access_sequencer: READ_LATENCY must be in 1..15");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Counter value loaded on ADDR exit: READ finishes when it reaches zero.
  localparam logic [3:0] RD_CNT_INIT = 4'(READ_LATENCY - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_is_write;
  logic [3:0]          r_rd_cnt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_data;
  logic [DATA_W-1:0]   r_resp_data;
  logic                w_accept;
  logic                w_rd_last;

  assign w_accept  = in_req_valid && out_req_ready;
  assign w_rd_last = (r_state == ST_READ) && (r_rd_cnt == 4'd0);

  // Next state and state-decoded outputs. Ready is masked while reset is
  // asserted so an upstream valid is never seen as accepted and then dropped.
  always_comb begin
    w_state_nxt           = r_state;
    out_req_ready         = 1'b0;
    out_mem_addr_write_en = 1'b0;
    out_mem_read_en       = 1'b0;
    out_mem_write_en      = 1'b0;
    out_resp_valid        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        out_req_ready = !rst;
        if (w_accept) begin
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        out_mem_addr_write_en = 1'b1;
        w_state_nxt = r_is_write ? ST_WRITE : ST_READ;
      end
      ST_WRITE: begin
        out_mem_write_en = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_READ: begin
        out_mem_read_en = 1'b1;
        if (r_rd_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        out_resp_valid = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_is_write  <= 1'b0;
      r_rd_cnt    <= 4'd0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_state_nxt;

      // Request fields are captured only at accept; address and data then stay
      // stable through RESP and are retained while idle.
      if (w_accept) begin
        r_is_write <= in_req_write;
        r_mem_addr <= in_req_addr;
        r_mem_data <= in_req_data;
      end

      if (r_state == ST_ADDR) begin
        r_rd_cnt <= RD_CNT_INIT;
      end else if ((r_state == ST_READ) && (r_rd_cnt != 4'd0)) begin
        r_rd_cnt <= r_rd_cnt - 4'd1;
      end

      // Load data is sampled on the edge that ends the last read cycle;
      // a store reports zero data.
      if (w_rd_last) begin
        r_resp_data <= in_mem_data;
      end else if (r_state == ST_WRITE) begin
        r_resp_data <= '0;
      end
    end
  end

  assign out_mem_addr  = r_mem_addr;
  assign out_mem_data  = r_mem_data;
  assign out_resp_data = r_resp_data;

  // Strobes are mutually exclusive by construction of the state decode.
  a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({out_mem_addr_write_en, out_mem_read_en, out_mem_write_en, out_resp_valid}));

  // No request can be taken while a transaction is in flight.
  a_ready_idle_only: assert property (@(posedge clk) disable iff (rst)
    out_req_ready |-> (r_state == ST_IDLE));

endmodule

// File: tb/tb_data_mem_access_sequencer.sv
// Bench for data_mem_access_sequencer: one READ_LATENCY=1 and one READ_LATENCY=3 instance
// share clock, reset and request fields; sel routes the request valid and the observed outputs.
// Memory model: small fixed contents plus the most recent store.
module tb_data_mem_access_sequencer;

  logic       clk;
  logic       rst;
  logic       sel;
  logic       req_vld;
  logic       req_wr;
  logic [9:0] req_addr;
  logic [7:0] req_data;

  logic       vld1, rdy1, aw1, rd1, wr1, rv1;
  logic [9:0] maddr1;
  logic [7:0] mdata1, mrd1, rdata1;
  logic       vld3, rdy3, aw3, rd3, wr3, rv3;
  logic [9:0] maddr3;
  logic [7:0] mdata3, mrd3, rdata3;

  logic       wr_v;
  logic [9:0] wr_a;
  logic [7:0] wr_d;

  // Observed: {ready, addr_we, read_en, write_en, resp_valid}
  logic [4:0] obs_vec;
  logic [9:0] obs_addr;
  logic [7:0] obs_mdata;
  logic [7:0] obs_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  assign vld1 = req_vld & ~sel;
  assign vld3 = req_vld & sel;

  data_mem_access_sequencer #(.ADDR_W(10), .DATA_W(8), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_req_valid(vld1), .out_req_ready(rdy1),
    .in_req_write(req_wr), .in_req_addr(req_addr), .in_req_data(req_data),
    .out_mem_addr_write_en(aw1), .out_mem_addr(maddr1),
    .out_mem_read_en(rd1), .out_mem_write_en(wr1), .out_mem_data(mdata1),
    .in_mem_data(mrd1),
    .out_resp_valid(rv1), .out_resp_data(rdata1)
  );

  data_mem_access_sequencer #(.ADDR_W(10), .DATA_W(8), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_req_valid(vld3), .out_req_ready(rdy3),
    .in_req_write(req_wr), .in_req_addr(req_addr), .in_req_data(req_data),
    .out_mem_addr_write_en(aw3), .out_mem_addr(maddr3),
    .out_mem_read_en(rd3), .out_mem_write_en(wr3), .out_mem_data(mdata3),
    .in_mem_data(mrd3),
    .out_resp_valid(rv3), .out_resp_data(rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [9:0] a);
    case (a)
      10'h2C0: return 8'hA5;
      10'h3FF: return 8'h5C;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    mrd1 = rom(maddr1);
    if (wr_v && (wr_a == maddr1)) mrd1 = wr_d;
    mrd3 = rom(maddr3);
    if (wr_v && (wr_a == maddr3)) mrd3 = wr_d;
  end

  always @(posedge clk) begin
    if (rst) begin
      wr_v <= 1'b0;
    end else if (wr1) begin
      wr_v <= 1'b1;
      wr_a <= maddr1;
      wr_d <= mdata1;
    end else if (wr3) begin
      wr_v <= 1'b1;
      wr_a <= maddr3;
      wr_d <= mdata3;
    end
  end

  always_comb begin
    if (sel) begin
      obs_vec   = {rdy3, aw3, rd3, wr3, rv3};
      obs_addr  = maddr3;
      obs_mdata = mdata3;
      obs_rdata = rdata3;
    end else begin
      obs_vec   = {rdy1, aw1, rd1, wr1, rv1};
      obs_addr  = maddr1;
      obs_mdata = mdata1;
      obs_rdata = rdata1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Presents a request, checks every cycle from ADDR to
  // the first IDLE cycle after RESP, and returns at that negedge. With chain
  // set, valid stays high and the fields switch to the next request.
  task automatic run_txn(input string tag, input bit wr, input logic [9:0] a,
                         input logic [7:0] d, input int rl, input logic [7:0] exp_rd,
                         input bit chain, input bit nwr, input logic [9:0] na,
                         input logic [7:0] nd);
    int lat;
    logic [4:0] ev;
    lat = wr ? 3 : 2 + rl;
    req_vld  = 1'b1;
    req_wr   = wr;
    req_addr = a;
    req_data = d;
    chk({tag, " ready_at_req"}, 32'(obs_vec[4]), 32'd1);
    @(posedge clk);
    #1;
    if (chain) begin
      req_wr   = nwr;
      req_addr = na;
      req_data = nd;
    end else begin
      req_vld  = 1'b0;
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      ev = 5'b00000;
      ev[3] = (k == 1);
      ev[2] = !wr && (k >= 2) && (k <= 1 + rl);
      ev[1] = wr && (k == 2);
      ev[0] = (k == lat);
      chk($sformatf("%s strobes c%0d", tag, k), 32'(obs_vec), 32'(ev));
      if (k == 1) chk({tag, " mem_addr"}, 32'(obs_addr), 32'(a));
      if (wr && k == 2) chk({tag, " mem_data"}, 32'(obs_mdata), 32'(d));
      if (k == lat) chk({tag, " resp_data"}, 32'(obs_rdata), 32'(exp_rd));
    end
    @(negedge clk);
    chk({tag, " back_to_idle"}, 32'(obs_vec), 32'h10);
  endtask

  initial begin
    rst      = 1'b1;
    sel      = 1'b0;
    req_vld  = 1'b1;
    req_wr   = 1'b0;
    req_addr = 10'h000;
    req_data = 8'h00;

    // Reset held three cycles with valid asserted.
    repeat (3) begin
      @(negedge clk);
      chk("rst strobes", 32'(obs_vec[3:0]), 32'd0);
    end
    chk("rst mem_addr", 32'(obs_addr), 32'd0);
    chk("rst resp_data", 32'(obs_rdata), 32'd0);
    rst     = 1'b0;
    req_vld = 1'b0;
    #1;
    chk("rst ready_after_release", 32'(obs_vec[4]), 32'd1);
    @(negedge clk);
    chk("rst idle", 32'(obs_vec), 32'h10);

    // Single store and load on the READ_LATENCY=1 instance.
    run_txn("store155", 1'b1, 10'h155, 8'h3A, 1, 8'h00, 1'b0, 1'b0, 10'h0, 8'h0);
    run_txn("load2C0", 1'b0, 10'h2C0, 8'hFF, 1, 8'hA5, 1'b0, 1'b0, 10'h0, 8'h0);

    // Valid held high: load then store; the store is accepted in the IDLE
    // cycle right after the load's RESP.
    run_txn("b2b_load", 1'b0, 10'h155, 8'h00, 1, 8'h3A, 1'b1, 1'b1, 10'h0AB, 8'h77);
    run_txn("b2b_store", 1'b1, 10'h0AB, 8'h77, 1, 8'h00, 1'b0, 1'b0, 10'h0, 8'h0);

    // READ_LATENCY=3 instance.
    sel = 1'b1;
    #1;
    chk("rl3 idle", 32'(obs_vec), 32'h10);
    @(negedge clk);
    run_txn("rl3_load3FF", 1'b0, 10'h3FF, 8'h00, 3, 8'h5C, 1'b0, 1'b0, 10'h0, 8'h0);

    // Reset in the middle of READ aborts without a response.
    req_vld  = 1'b1;
    req_wr   = 1'b0;
    req_addr = 10'h2C0;
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    @(negedge clk);
    chk("abort addr", 32'(obs_vec), 32'h08);
    @(negedge clk);
    chk("abort read", 32'(obs_vec), 32'h04);
    rst = 1'b1;
    @(negedge clk);
    chk("abort in_reset", 32'(obs_vec), 32'h00);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort no_resp c%0d", k), 32'(obs_vec), 32'h10);
    end
    run_txn("after_abort", 1'b0, 10'h2C0, 8'h00, 3, 8'hA5, 1'b0, 1'b0, 10'h0, 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
